data_mem_responder: RTL and testbench

Synthesizable data-memory responder for the MIPS single-cycle/multi-cycle datapath: it answers the CPU's data-side requests (`dataMemAddress`, `dataMemRead`, `dataMemWrite`, `dataWriteValue`) with `dataReadValue`, a `dataMemReady` handshake and an error flag. It replaces the behavioural memory model with a word-organised RAM behind a fixed-latency request FSM, so stall logic in the datapath can be exercised. It sits between the datapath's data port and on-chip RAM, mapped at the `.data` segment base.

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/word_ram.sv | 41 ++++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MIPS memory-side blocks: responder FSM states,
// segment base addresses, word width and the request address check.
// No ports (package).
package mips_mem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An offset from the segment base is bad when it runs past the last word or
  // is not word aligned. Addresses below the base wrap to huge offsets, so
  // one unsigned compare covers both ends of the window.
  function automatic logic offset_bad(input logic [31:0] off,
                                      input int unsigned depth_words);
    return (off >= 32'(depth_words * 4)) || (off[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/word_ram.sv
// word_ram
// Synchronous single-port word RAM with a registered read port.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    async active-high reset (read register only; array not reset)
//   i_we     write enable: r_mem[i_addr] <= i_wdata
//   i_re     read enable: o_rdata <= r_mem[i_addr]
//   i_clr    clear read register to zero (used for rejected requests)
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data, held between enables
module word_ram import mips_mem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-side memory responder for the MIPS datapath: word RAM mapped at
// BASE_ADDR behind a fixed-latency IDLE -> BUSY -> RESP request FSM.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   dataMemAddress    byte address of the request
//   dataMemRead/Write request strobes, sampled only in IDLE
//   dataWriteValue    write data
//   dataReadValue     registered read data (valid with dataMemReady)
//   dataMemReady      one-cycle response strobe (RESP state)
//   dataMemError      request rejected; only high together with dataMemReady
//   dataMemBusy       high in BUSY and RESP
//   o_dbg_state       current FSM state for observation
// Handshake: a request (read|write) is taken on any edge where the FSM is in
// IDLE; exactly one dataMemReady pulse follows LATENCY edges later. Request
// inputs are ignored in BUSY and RESP, and a requester must drop its request
// in the cycle it sees dataMemReady or it is taken again.
module data_mem_responder import mips_mem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = DATA_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       dataMemAddress,
  input  logic              dataMemRead,
  input  logic              dataMemWrite,
  input  logic [WORD_W-1:0] dataWriteValue,
  output logic [WORD_W-1:0] dataReadValue,
  output logic              dataMemReady,
  output logic              dataMemError,
  output logic              dataMemBusy,
  output state_t            o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_count;
  logic [AW-1:0]     r_index;
  logic [WORD_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_err;

  logic [31:0]       w_offset;
  logic              w_accept;
  logic              w_access;
  logic              w_ram_we;
  logic              w_ram_re;
  logic              w_ram_clr;
  logic [WORD_W-1:0] w_ram_rdata;

  assign w_offset = dataMemAddress - BASE_ADDR;
  assign w_accept = (r_state == ST_IDLE) && (dataMemRead || dataMemWrite);
  // The access edge is the one that moves BUSY -> RESP.
  assign w_access = (r_state == ST_BUSY) && (r_count == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Request latch and latency counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count    <= 4'd0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_count    <= 4'(LATENCY - 1);
      r_index    <= w_offset[AW+1:2];
      r_wdata    <= dataWriteValue;
      r_is_write <= dataMemWrite;
      r_err      <= offset_bad(w_offset, DEPTH_WORDS) ||
                    (dataMemRead && dataMemWrite);
    end else if ((r_state == ST_BUSY) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_ram_clr    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
      ST_BUSY: begin
        if (w_access) begin
          w_next_state = ST_RESP;
          w_ram_we     = r_is_write && !r_err;
          w_ram_re     = !r_is_write && !r_err;
          w_ram_clr    = r_err;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_clr   (w_ram_clr),
    .i_addr  (r_index),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // All outputs come from registers, so reset clears them immediately and no
  // request input reaches an output combinationally.
  assign dataReadValue = w_ram_rdata;
  assign dataMemReady  = (r_state == ST_RESP);
  assign dataMemError  = (r_state == ST_RESP) && r_err;
  assign dataMemBusy   = (r_state != ST_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Bench for data_mem_responder: a LATENCY=2 instance driven by directed and
// random requests with a scoreboard, plus a LATENCY=1 instance used for the
// held-read cadence check.
module tb_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (LATENCY=2) ----------------
  logic [31:0] a_addr, a_wdata, rdval;
  logic        a_rd, a_wr, ready, err, busy;
  state_t      st0;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clock          (clk),
    .reset          (rst),
    .dataMemAddress (a_addr),
    .dataMemRead    (a_rd),
    .dataMemWrite   (a_wr),
    .dataWriteValue (a_wdata),
    .dataReadValue  (rdval),
    .dataMemReady   (ready),
    .dataMemError   (err),
    .dataMemBusy    (busy),
    .o_dbg_state    (st0)
  );

  // ---------------- DUT (LATENCY=1) ----------------
  logic [31:0] b_rdval;
  logic        b_rd, b_ready, b_err, b_busy;
  state_t      st1;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clock          (clk),
    .reset          (rst),
    .dataMemAddress (BASE),
    .dataMemRead    (b_rd),
    .dataMemWrite   (1'b0),
    .dataWriteValue (32'h0),
    .dataReadValue  (b_rdval),
    .dataMemReady   (b_ready),
    .dataMemError   (b_err),
    .dataMemBusy    (b_busy),
    .o_dbg_state    (st1)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model [16];   // words 0..15 of the data segment
  logic [31:0] hold;         // value dataReadValue should currently show
  logic [64:0] exp_q [$];    // {expected ready cycle, error, read value}
  logic [64:0] mon_ent;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Legal = inside [BASE, BASE + 4*DEPTH) and word aligned, computed without wrap.
  function automatic bit addr_legal(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off < 4 * DEPTH) && (off % 4 == 0);
  endfunction

  // Monitor: every response is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_resp: got ready=1 err=%b data=%h expected no response", err, rdval);
      end else begin
        mon_ent = exp_q.pop_front();
        check("resp_cycle", cyc, mon_ent[64:33]);
        check("resp_error", {31'h0, err}, {31'h0, mon_ent[32]});
        check("resp_data", rdval, mon_ent[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drop_req();
    a_rd = 1'b0;
    a_wr = 1'b0;
    a_addr = 32'h0;
    a_wdata = 32'h0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [31:0] wdata, input bit toggle);
    logic [31:0] exp_d;
    bit e;
    bit got;
    int idx;
    @(negedge clk);
    a_addr = addr; a_rd = rd; a_wr = wr; a_wdata = wdata;
    e = !addr_legal(addr) || (rd && wr);
    if (e) begin
      exp_d = 32'h0;
      hold = 32'h0;
    end else begin
      idx = int'((addr - BASE) >> 2);
      if (wr) begin
        model[idx] = wdata;
        exp_d = hold;
      end else begin
        exp_d = model[idx];
        hold = exp_d;
      end
    end
    exp_q.push_back({32'(cyc + 1 + LAT), e, exp_d});
    @(negedge clk);
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    if (!toggle) drop_req();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ready) got = 1'b1;
      else begin
        if (toggle) begin
          a_rd = 1'($urandom); a_wr = 1'($urandom);
          a_addr = $urandom; a_wdata = $urandom;
        end
        @(negedge clk);
      end
    end
    drop_req();
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: got no ready expected ready within 20 cycles of %h", addr);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    logic [31:0] leg;
    bit found;
    int kind;
    drop_req();
    b_rd = 1'b0;
    hold = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_error", {31'h0, err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdval", rdval, 32'h0);
    check("rst_state", {30'h0, st0}, {30'h0, ST_IDLE});
    rst = 1'b0;

    // Give words 0..15 known contents
    for (int i = 0; i < 16; i++) issue(BASE + 32'(4 * i), 1'b0, 1'b1, $urandom, 1'b0);

    // Write then read back the same word
    issue(32'h1001_0004, 1'b0, 1'b1, 32'h0000_00C8, 1'b0);
    issue(32'h1001_0004, 1'b1, 1'b0, 32'h0, 1'b0);

    // Out-of-window and misaligned reads, then word 0 must be intact
    issue(32'h1000_FFFC, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h1001_1000, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h1001_0002, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h1001_0000, 1'b1, 1'b0, 32'h0, 1'b0);

    // Read and write together is rejected; word 2 keeps its value
    issue(32'h1001_0008, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0);
    issue(32'h1001_0008, 1'b1, 1'b0, 32'h0, 1'b0);

    // Inputs toggled while BUSY must not create extra responses
    issue(32'h1001_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    issue(32'h1001_0010, 1'b1, 1'b0, 32'h0, 1'b0);

    // Random mix of legal reads/writes and each flavour of rejected request
    for (int n = 0; n < 40; n++) begin
      leg = BASE + 32'(4 * $urandom_range(0, 15));
      kind = $urandom_range(0, 9);
      case (kind)
        0: issue(BASE - 32'(4 * $urandom_range(1, 64)), 1'b1, 1'b0, 32'h0, 1'b0);
        1: issue(BASE + 32'h1000 + 32'(4 * $urandom_range(0, 64)), 1'b0, 1'b1, $urandom, 1'b0);
        2: issue(leg + 32'($urandom_range(1, 3)), 1'($urandom), 1'b1, $urandom, 1'b0);
        3: issue(leg, 1'b1, 1'b1, $urandom, 1'b0);
        4, 5, 6: issue(leg, 1'b0, 1'b1, $urandom, 1'($urandom));
        default: issue(leg, 1'b1, 1'b0, 32'h0, 1'($urandom));
      endcase
    end

    // Reset while a write is pending: write discarded, outputs drop at once
    @(negedge clk);
    a_addr = 32'h1001_0014; a_wr = 1'b1; a_wdata = 32'h1234_5678;
    @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    drop_req();
    #1;
    check("midrst_ready", {31'h0, ready}, 32'h0);
    check("midrst_error", {31'h0, err}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_state", {30'h0, st0}, {30'h0, ST_IDLE});
    hold = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    issue(32'h1001_0014, 1'b1, 1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);

    // LATENCY=1 instance with read held high: ready every 3rd cycle,
    // BUSY for exactly the cycle before each ready
    @(negedge clk);
    b_rd = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("lat1_first_ready", {31'h0, found}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      check("lat1_ready", {31'h0, b_ready}, {31'h0, (i % 3) == 0});
      check("lat1_busy_state", {31'h0, st1 == ST_BUSY}, {31'h0, (i % 3) == 2});
      @(negedge clk);
    end
    b_rd = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
